// File: rtl/window_frame_pkg.sv
// Shared constants and helpers for the analysis-window stage: width derivations
// and the Hann coefficient generator used to build the coefficient ROM.
package window_frame_pkg;

  localparam int DEF_FFT_SIZE     = 4096;
  localparam int DEF_SAMPLE_WIDTH = 16;
  localparam int WIN_COEF_WIDTH   = 16;
  localparam real WIN_PI          = 3.14159265358979323846;

  function automatic int win_addr_width(int fft_size);
    return $clog2(fft_size);
  endfunction

  function automatic int in_axi_width(int sample_width);
    return 2 * sample_width;
  endfunction

  function automatic int in_byte_count(int sample_width);
    return in_axi_width(sample_width) / 8;
  endfunction

  // round((2^cw-1) * 0.5 * (1 - cos(2*pi*n/size))), evaluated at elaboration
  function automatic int win_coef(int n, int size, int cw);
    real scale;
    real x;
    scale = real'((1 << cw) - 1);
    x = scale * 0.5 * (1.0 - $cos(2.0 * WIN_PI * real'(n) / real'(size)));
    return $rtoi(x + 0.5);
  endfunction

endpackage

// File: rtl/window_frame_if.sv
// AXI-stream bundle around the window stage: audio sample input and the
// packed two-sample beat output towards the FFT.
interface window_frame_if #(
  parameter int SAMPLE_WIDTH = 16
);
  import window_frame_pkg::*;

  localparam int OW = in_axi_width(SAMPLE_WIDTH);
  localparam int KW = in_byte_count(SAMPLE_WIDTH);

  logic                    s_axis_audio_tvalid;
  logic                    s_axis_audio_tready;
  logic [SAMPLE_WIDTH-1:0] s_axis_audio_tdata;
  logic                    axis_win2fft_tvalid;
  logic                    axis_win2fft_tready;
  logic [OW-1:0]           axis_win2fft_tdata;
  logic [KW-1:0]           axis_win2fft_tkeep;
  logic                    axis_win2fft_tlast;

  // slave: the window stage itself; master: the surrounding source/sink
  modport slave (
    input  s_axis_audio_tvalid, s_axis_audio_tdata, axis_win2fft_tready,
    output s_axis_audio_tready, axis_win2fft_tvalid, axis_win2fft_tdata,
    output axis_win2fft_tkeep, axis_win2fft_tlast
  );

  modport master (
    output s_axis_audio_tvalid, s_axis_audio_tdata, axis_win2fft_tready,
    input  s_axis_audio_tready, axis_win2fft_tvalid, axis_win2fft_tdata,
    input  axis_win2fft_tkeep, axis_win2fft_tlast
  );

endinterface

// File: rtl/window_rom.sv
// Hann coefficient ROM with one-cycle registered read; contents are computed
// at elaboration so no external init file is needed.
module window_rom #(
  parameter int FFT_SIZE   = 4096,
  parameter int COEF_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        i_en,
  input  logic [$clog2(FFT_SIZE)-1:0] i_addr,
  output logic [COEF_WIDTH-1:0]       o_data
);
  import window_frame_pkg::*;

  logic [COEF_WIDTH-1:0] w_rom [FFT_SIZE];
  logic [COEF_WIDTH-1:0] r_data;

  for (genvar gi = 0; gi < FFT_SIZE; gi++) begin : g_rom
    assign w_rom[gi] = COEF_WIDTH'(win_coef(gi, FFT_SIZE, COEF_WIDTH));
  end

  always_ff @(posedge clk) begin
    if (i_en) begin
      r_data <= w_rom[i_addr];
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/window_frame.sv
// Hann analysis window: multiplies each audio sample by its frame-position
// coefficient and packs even/odd results into one AXI-stream beat per pair.
module window_frame #(
  parameter int FFT_SIZE     = window_frame_pkg::DEF_FFT_SIZE,
  parameter int SAMPLE_WIDTH = window_frame_pkg::DEF_SAMPLE_WIDTH,
  parameter int COEF_WIDTH   = window_frame_pkg::WIN_COEF_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          win_en,
  window_frame_if.slave axis,
  output logic          win_busy,
  output logic          frame_done
);
  import window_frame_pkg::*;

  localparam int SW = SAMPLE_WIDTH;
  localparam int CW = COEF_WIDTH;
  localparam int PW = SW + CW;
  localparam int AW = win_addr_width(FFT_SIZE);
  localparam int OW = in_axi_width(SW);
  localparam int KW = in_byte_count(SW);
  localparam logic [AW-1:0] LAST_IDX = AW'(FFT_SIZE - 1);

  logic w_advance, w_in_hs, w_out_hs, w_tlast_hs;
  logic [AW-1:0] r_idx;
  logic          r_in_open;
  logic                 r_s1_valid;
  logic [AW-1:0]        r_s1_idx;
  logic signed [SW-1:0] r_s1_sample;
  logic [CW-1:0]        w_coef;
  logic signed [PW-1:0] w_sample_ext, w_coef_ext, w_product;
  logic                 w_prod_unused;
  logic                 r_s2_valid;
  logic [AW-1:0]        r_s2_idx;
  logic signed [SW-1:0] r_s2_result;
  logic signed [SW-1:0] r_pack;
  logic                 r_out_valid, r_out_last;
  logic [OW-1:0]        r_out_data;
  logic                 r_busy, r_frame_done;

  // One enable for every stage: the whole pipe freezes while a beat waits
  assign w_advance  = !r_out_valid || axis.axis_win2fft_tready;
  assign axis.s_axis_audio_tready = w_advance && !reset && (r_in_open || win_en);
  assign w_in_hs    = axis.s_axis_audio_tvalid && axis.s_axis_audio_tready;
  assign w_out_hs   = r_out_valid && axis.axis_win2fft_tready;
  assign w_tlast_hs = w_out_hs && r_out_last;

  // r_in_open is set by sample 0 and cleared by sample FFT_SIZE-1
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx     <= '0;
      r_in_open <= 1'b0;
    end else if (w_in_hs) begin
      r_idx     <= r_idx + 1'b1;
      r_in_open <= (r_idx != LAST_IDX);
    end
  end

  window_rom #(
    .FFT_SIZE   (FFT_SIZE),
    .COEF_WIDTH (CW)
  ) u_rom (
    .clk    (clk),
    .i_en   (w_advance),
    .i_addr (r_idx),
    .o_data (w_coef)
  );

  // Coefficient is zero-extended so the product stays signed; |coef| < 1.0
  assign w_sample_ext  = PW'(r_s1_sample);
  assign w_coef_ext    = PW'(w_coef);
  assign w_product     = w_sample_ext * w_coef_ext;
  assign w_prod_unused = ^w_product[CW-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else if (w_advance) begin
      r_s1_valid <= w_in_hs;
      r_s2_valid <= r_s1_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (w_advance) begin
      r_s1_idx    <= r_idx;
      r_s1_sample <= axis.s_axis_audio_tdata;
      r_s2_idx    <= r_s1_idx;
      r_s2_result <= w_product[PW-1:CW];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pack      <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
    end else if (w_advance) begin
      r_out_valid <= r_s2_valid && r_s2_idx[0];
      if (r_s2_valid && !r_s2_idx[0]) begin
        r_pack <= r_s2_result;
      end
      if (r_s2_valid && r_s2_idx[0]) begin
        r_out_data <= {r_s2_result, r_pack};
        r_out_last <= (r_s2_idx == LAST_IDX);
      end
    end
  end

  // A later frame may already be open when the tlast beat leaves
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_tlast_hs;
      r_busy       <= (w_in_hs && r_idx == '0) || (r_busy && !(w_tlast_hs && !r_in_open));
    end
  end

  assign axis.axis_win2fft_tvalid = r_out_valid;
  assign axis.axis_win2fft_tdata  = r_out_data;
  assign axis.axis_win2fft_tlast  = r_out_last;
  assign axis.axis_win2fft_tkeep  = {KW{r_out_valid}};
  assign win_busy   = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_window_frame.sv
// Randomised bench for window_frame (FFT_SIZE=8) against a sample-level
// reference model, plus hand-computed expectations for the directed cases.
module tb_window_frame;
  localparam int N = 8;
  localparam int SW = 16;
  localparam real PI = 3.14159265358979323846;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic win_en = 1'b1;
  logic win_busy, frame_done;

  always #5 clk = ~clk;

  window_frame_if #(.SAMPLE_WIDTH(SW)) aif ();

  window_frame #(
    .FFT_SIZE     (N),
    .SAMPLE_WIDTH (SW),
    .COEF_WIDTH   (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .win_en     (win_en),
    .axis       (aif),
    .win_busy   (win_busy),
    .frame_done (frame_done)
  );

  int checks = 0;
  int errors = 0;

  // model state
  int          m_idx = 0;
  logic [15:0] m_even = '0;
  beat_t       exp_q[$];
  int          m_started = 0, m_completed = 0, m_frame_beats = 0, m_in_total = 0;
  bit          m_prev_tlast_hs = 0;
  bit          prev_stall = 0, rst_seen = 0;
  logic [31:0] prev_data;
  logic        prev_last;
  int          cyc = 0;

  // observation logs for directed checks
  logic [31:0] log_data[$];
  logic        log_last[$];
  int          log_cycle[$];
  int          done_pulses = 0;
  int          t_n1 = -1, t_v1 = -1;

  // driver configuration
  int          drv_limit = 0, drv_in_pct = 100, drv_out_pct = 100;
  bit          drv_rand = 0;
  logic [15:0] drv_const = 16'h4000;

  task automatic chk(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int hann(int n);
    real x;
    x = 65535.0 * 0.5 * (1.0 - $cos(2.0 * PI * real'(n) / real'(N)));
    return int'(x);
  endfunction

  function automatic logic [15:0] windowed(logic [15:0] s, int n);
    longint p;
    p = longint'($signed(s)) * longint'(hann(n));
    return 16'(p >>> 16);
  endfunction

  initial begin : drv
    aif.s_axis_audio_tvalid = 1'b0;
    aif.s_axis_audio_tdata  = '0;
    aif.axis_win2fft_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      aif.s_axis_audio_tvalid = (m_in_total < drv_limit) && ($urandom_range(99) < drv_in_pct);
      aif.s_axis_audio_tdata  = drv_rand ? 16'($urandom) : drv_const;
      aif.axis_win2fft_tready = ($urandom_range(99) < drv_out_pct);
    end
  end

  initial begin : mon
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        if (rst_seen)
          chk("reset_state", longint'({aif.s_axis_audio_tready, aif.axis_win2fft_tvalid,
              aif.axis_win2fft_tlast, win_busy, frame_done, aif.axis_win2fft_tdata}), 0);
        rst_seen = 1;
        m_idx = 0;
        exp_q.delete();
        m_started = 0;
        m_completed = 0;
        m_frame_beats = 0;
        m_prev_tlast_hs = 0;
        prev_stall = 0;
      end else begin : active
        bit in_hs, out_hs, exp_rdy;
        beat_t b;
        rst_seen = 0;
        in_hs  = aif.s_axis_audio_tvalid && aif.s_axis_audio_tready;
        out_hs = aif.axis_win2fft_tvalid && aif.axis_win2fft_tready;
        exp_rdy = (!aif.axis_win2fft_tvalid || aif.axis_win2fft_tready) && (m_idx != 0 || win_en);
        chk("s_tready", aif.s_axis_audio_tready, exp_rdy);
        chk("win_busy", win_busy, m_started > m_completed);
        chk("frame_done", frame_done, m_prev_tlast_hs);
        if (prev_stall) begin
          chk("stall_tvalid", aif.axis_win2fft_tvalid, 1);
          chk("stall_tdata", aif.axis_win2fft_tdata, prev_data);
          chk("stall_tlast", aif.axis_win2fft_tlast, prev_last);
        end
        if (aif.axis_win2fft_tvalid) chk("tkeep", aif.axis_win2fft_tkeep, 4'hF);
        if (frame_done) done_pulses++;
        if (aif.axis_win2fft_tvalid && t_v1 < 0) t_v1 = cyc;
        if (in_hs) begin
          logic [15:0] r;
          if (m_idx == 1 && t_n1 < 0) t_n1 = cyc;
          if (m_idx == 0) m_started++;
          r = windowed(aif.s_axis_audio_tdata, m_idx);
          if (m_idx % 2 == 0) m_even = r;
          else exp_q.push_back('{data: {r, m_even}, last: (m_idx == N - 1)});
          m_idx = (m_idx + 1) % N;
          m_in_total++;
        end
        if (out_hs) begin
          log_data.push_back(aif.axis_win2fft_tdata);
          log_last.push_back(aif.axis_win2fft_tlast);
          log_cycle.push_back(cyc);
          if (exp_q.size() == 0) begin
            chk("beat_unexpected", 1, 0);
          end else begin
            b = exp_q.pop_front();
            chk("beat_data", aif.axis_win2fft_tdata, b.data);
            chk("beat_last", aif.axis_win2fft_tlast, b.last);
          end
          m_frame_beats++;
          if (aif.axis_win2fft_tlast) begin
            chk("beats_per_frame", m_frame_beats, N / 2);
            m_frame_beats = 0;
            m_completed++;
          end
        end
        m_prev_tlast_hs = out_hs && aif.axis_win2fft_tlast;
        prev_stall = aif.axis_win2fft_tvalid && !aif.axis_win2fft_tready;
        prev_data  = aif.axis_win2fft_tdata;
        prev_last  = aif.axis_win2fft_tlast;
      end
    end
  end

  task automatic clear_logs();
    log_data.delete();
    log_last.delete();
    log_cycle.delete();
    done_pulses = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((m_in_total < drv_limit || exp_q.size() != 0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk("drain_timeout", n < 3000, 1);
    repeat (4) @(posedge clk);
  endtask

  task automatic wait_idx(int target);
    int n = 0;
    while (m_idx != target && n < 2000) begin
      @(posedge clk);
      n++;
    end
    chk("wait_idx_timeout", m_idx, target);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin : main
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);

    // constant +0.5 input, full rate, one frame
    #1;
    clear_logs();
    t_n1 = -1;
    t_v1 = -1;
    drv_rand = 0; drv_const = 16'h4000; drv_in_pct = 100; drv_out_pct = 100;
    drv_limit = m_in_total + N;
    drain();
    chk("t1_beats", log_data.size(), 4);
    if (log_data.size() == 4) begin
      chk("t1_beat0_even", log_data[0][15:0], 0);
      chk("t1_beat0_odd", log_data[0][31:16], 2399);
      chk("t1_beat2_even", log_data[2][15:0], 16383);
      for (int i = 0; i < 4; i++) chk("t1_tlast", log_last[i], i == 3);
    end
    chk("t1_done_pulses", done_pulses, 1);
    chk("t1_latency", t_v1 - t_n1, 3);

    // constant -0.5 input: floor behaviour at the window peak
    clear_logs();
    drv_const = 16'hC000;
    drv_limit = m_in_total + N;
    drain();
    chk("t2_beats", log_data.size(), 4);
    if (log_data.size() == 4) begin
      chk("t2_n4", log_data[2][15:0], 16'hC000);
      chk("t2_n0", log_data[0][15:0], 0);
    end

    // random data, random backpressure, three frames
    clear_logs();
    drv_rand = 1; drv_in_pct = 80; drv_out_pct = 50;
    drv_limit = m_in_total + 3 * N;
    drain();
    chk("t3_beats", log_data.size(), 12);
    chk("t3_done_pulses", done_pulses, 3);

    // back-to-back frames: one beat every two cycles across the boundary
    clear_logs();
    drv_in_pct = 100; drv_out_pct = 100;
    drv_limit = m_in_total + 2 * N;
    drain();
    chk("t4_beats", log_data.size(), 8);
    for (int i = 1; i < log_cycle.size(); i++) chk("t4_gap", log_cycle[i] - log_cycle[i-1], 2);

    // win_en dropped after sample 3: frame completes, then input closes
    clear_logs();
    drv_rand = 0; drv_const = 16'h4000;
    drv_limit = m_in_total + 100;
    wait_idx(4);
    #1 win_en = 1'b0;
    repeat (30) @(posedge clk);
    #2;
    chk("t5_beats", log_data.size(), 4);
    if (log_data.size() == 4) chk("t5_tlast", log_last[3], 1);
    chk("t5_tready_closed", aif.s_axis_audio_tready, 0);
    chk("t5_busy_low", win_busy, 0);
    drv_limit = m_in_total;
    repeat (2) @(posedge clk);
    #1 win_en = 1'b1;

    // reset after sample 5: partial frame discarded, next input is n=0
    drv_limit = m_in_total + 100;
    wait_idx(6);
    #1 reset = 1'b1;
    clear_logs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    drv_limit = m_in_total + N;
    drain();
    chk("t6_beats", log_data.size(), 4);
    if (log_data.size() == 4) begin
      chk("t6_first_even", log_data[0][15:0], 0);
      chk("t6_first_odd", log_data[0][31:16], 2399);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
